// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake and {D,V,C,Z} flags.
// Multiply is iterative shift-add and divide is iterative restoring, one step
// per BUSY cycle. All other opcodes finish in a single cycle.
// Optional feature macro: SEQ_ALU_WIDE_RESULT_EN adds the result_hi port,
// carrying the upper product half or the division remainder.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
`ifdef SEQ_ALU_WIDE_RESULT_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;       // multiplicand, or dividend/quotient shifter
  logic [WIDTH-1:0] b_q, b_d;       // multiplier shifter, or divisor
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
`ifdef SEQ_ALU_WIDE_RESULT_EN
  logic [WIDTH-1:0] hi_q, hi_d;
`endif

  // Single-cycle ALU, evaluated straight off the request inputs.
  logic [WIDTH:0]   sum_w, diff_w;
  logic [31:0]      lsh_amt, rsh_amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  // Iteration datapath for one multiply or divide step.
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] mul_a, mul_b, mul_acc, mul_lo;
`ifdef SEQ_ALU_WIDE_RESULT_EN
  logic [WIDTH:0]   mul_sum;
`endif
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_a, div_acc;
  logic [WIDTH-1:0] fin_res;

  // Combinational result and flags for all single-cycle opcodes.
  always_comb begin
    sum_w   = {1'b0, operand1} + {1'b0, operand2};
    diff_w  = {1'b0, operand1} - {1'b0, operand2};
    lsh_amt = 32'(operand2[SHW-1:0]);
    // A zero amount makes this equal to WIDTH, so the wrap term vanishes.
    rsh_amt = 32'(WIDTH) - lsh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SHL:  alu_res = operand1 << lsh_amt;
      OP_SHR:  alu_res = operand1 >> lsh_amt;
      OP_ROL:  alu_res = (operand1 << lsh_amt) | (operand1 >> rsh_amt);
      OP_ROR:  alu_res = (operand1 >> lsh_amt) | (operand1 << rsh_amt);
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_NAND: alu_res = ~(operand1 & operand2);
      OP_XNOR: alu_res = ~(operand1 ^ operand2);
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
      default: alu_res = '0;
    endcase
    alu_flags = {1'b0, alu_v, alu_c, (alu_res == '0)};
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    addend = b_q[0] ? a_q : '0;
`ifdef SEQ_ALU_WIDE_RESULT_EN
    // {acc, b} is the 2*WIDTH product register; the multiplier drains out
    // of the low half while product bits shift in from the top.
    mul_sum = {1'b0, acc_q} + {1'b0, addend};
    mul_acc = mul_sum[WIDTH:1];
    mul_b   = {mul_sum[0], b_q[WIDTH-1:1]};
    mul_a   = a_q;
    mul_lo  = mul_b;
`else
    // Only the low half is kept: accumulate the multiplicand shifted left.
    mul_acc = acc_q + addend;
    mul_b   = b_q >> 1;
    mul_a   = a_q << 1;
    mul_lo  = mul_acc;
`endif
    div_shift = {acc_q, a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = !div_diff[WIDTH];
    div_acc   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_a     = {a_q[WIDTH-2:0], div_ok};
    fin_res   = (op_q == OP_MUL) ? mul_lo : div_a;
  end

  // Next-state and datapath control for IDLE -> BUSY/DONE -> IDLE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef SEQ_ALU_WIDE_RESULT_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = opcode;
          a_d   = operand1;
          b_d   = operand2;
          acc_d = '0;
          cnt_d = '0;
          if (opcode == OP_MUL || (opcode == OP_DIV && operand2 != '0)) begin
            state_d = ST_BUSY;
          end else if (opcode == OP_DIV) begin
            state_d  = ST_DONE;
            result_d = '1;
            flags_d  = 4'b1000;
`ifdef SEQ_ALU_WIDE_RESULT_EN
            hi_d     = operand1;
`endif
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            flags_d  = alu_flags;
`ifdef SEQ_ALU_WIDE_RESULT_EN
            hi_d     = '0;
`endif
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          a_d   = mul_a;
          b_d   = mul_b;
          acc_d = mul_acc;
        end else begin
          a_d   = div_a;
          acc_d = div_acc;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = fin_res;
          flags_d  = {3'b000, (fin_res == '0)};
`ifdef SEQ_ALU_WIDE_RESULT_EN
          hi_d     = (op_q == OP_MUL) ? mul_acc : div_acc;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef SEQ_ALU_WIDE_RESULT_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef SEQ_ALU_WIDE_RESULT_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
`ifdef SEQ_ALU_WIDE_RESULT_EN
  assign result_hi = hi_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16) with an arithmetic reference model.
// Builds with or without SEQ_ALU_WIDE_RESULT_EN; result_hi is checked when present.
module tb_seq_alu;
  localparam int W   = 16;
  localparam int SHW = $clog2(W);

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] operand1, operand2;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
`ifdef SEQ_ALU_WIDE_RESULT_EN
  logic [W-1:0] result_hi;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
`ifdef SEQ_ALU_WIDE_RESULT_EN
    ,
    .result_hi (result_hi)
`endif
  );

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic [3:0] f, output logic [W-1:0] h);
    longint ua, ub, full, sa, sb, sr, maxs, mins;
    int s;
    logic [W-1:0] t;
    bit c, v, d;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    maxs = (longint'(1) << (W-1)) - 1;
    mins = -(longint'(1) << (W-1));
    s = int'(b[SHW-1:0]);
    c = 0; v = 0; d = 0; r = '0; h = '0; t = a;
    case (op)
      4'd0: begin full = ua + ub; r = W'(full); c = (full >> W) != 0;
                  sr = sa + sb; v = (sr > maxs) || (sr < mins); end
      4'd1: begin full = ua - ub; r = W'(full); c = ua < ub;
                  sr = sa - sb; v = (sr > maxs) || (sr < mins); end
      4'd2: begin full = ua * ub; r = W'(full); h = W'(full >> W); end
      4'd3: if (ub == 0) begin r = '1; h = a; d = 1; end
            else begin r = W'(ua / ub); h = W'(ua % ub); end
      4'd4: r = W'(ua << s);
      4'd5: r = W'(ua >> s);
      4'd6: begin repeat (s) t = {t[W-2:0], t[W-1]}; r = t; end
      4'd7: begin repeat (s) t = {t[0], t[W-1:1]}; r = t; end
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = (ua > ub) ? W'(1) : W'(0);
      default: r = (ua == ub) ? W'(1) : W'(0);
    endcase
    f = {d, v, c, (r == '0)};
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input logic [W-1:0] b);
    return (op == 4'd2 || (op == 4'd3 && b != '0)) ? W + 1 : 1;
  endfunction

  // Issues one request with out_ready high; returns the observed response.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] f, output logic [W-1:0] h,
                        output int lat, output bit ready_seen, output bit timed_out);
    int n;
    timed_out = 0; ready_seen = 0; lat = 0; r = '0; f = '0; h = '0;
    @(negedge clk);
    opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin timed_out = 1; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    // Scramble the inputs: the block must work from its captured copy.
    in_valid = 1'b0; opcode = 4'($urandom); operand1 = W'($urandom); operand2 = W'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1;
      lat++;
      @(negedge clk);
    end
    if (!out_valid) timed_out = 1;
    r = result; f = flags;
`ifdef SEQ_ALU_WIDE_RESULT_EN
    h = result_hi;
`endif
    $display("op=%b a=%h b=%h -> result=%h flags=%b latency=%0d", op, a, b, r, f, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin mismatched++;
      $display("FAIL reset_in_ready_during_reset: got %b expected 0", in_ready); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    compared++;
    if (result !== '0) begin mismatched++;
      $display("FAIL reset_result: got %h expected 0000", result); end
    compared++;
    if (flags !== 4'b0) begin mismatched++;
      $display("FAIL reset_flags: got %b expected 0000", flags); end
    compared++;
    if (in_ready !== 1'b1) begin mismatched++;
      $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
`ifdef SEQ_ALU_WIDE_RESULT_EN
    compared++;
    if (result_hi !== '0) begin mismatched++;
      $display("FAIL reset_result_hi: got %h expected 0000", result_hi); end
`endif
    $display("reset sequence complete");
  endtask

  // Directed vectors with hand-computed expectations.
  logic [3:0]   dir_op  [6] = '{4'd0, 4'd1, 4'd4, 4'd2, 4'd3, 4'd3};
  logic [W-1:0] dir_a   [6] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h0123, 16'h03E8, 16'h1234};
  logic [W-1:0] dir_b   [6] = '{16'h0001, 16'h0001, 16'h000F, 16'h0456, 16'h0007, 16'h0000};
  logic [W-1:0] dir_r   [6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hEDC2, 16'h008E, 16'hFFFF};
  logic [3:0]   dir_f   [6] = '{4'b0011, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
  logic [W-1:0] dir_h   [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0006, 16'h1234};
  int           dir_lat [6] = '{1, 1, 1, 17, 17, 1};

  task automatic test_directed();
    logic [W-1:0] r, h; logic [3:0] f; int lat; bit rs, to;
    for (int i = 0; i < 6; i++) begin
      run_op(dir_op[i], dir_a[i], dir_b[i], r, f, h, lat, rs, to);
      compared++;
      if (to) begin mismatched++; $display("FAIL dir%0d_timeout: no response", i); continue; end
      compared++;
      if (r !== dir_r[i]) begin mismatched++;
        $display("FAIL dir%0d_result: got %h expected %h", i, r, dir_r[i]); end
      compared++;
      if (f !== dir_f[i]) begin mismatched++;
        $display("FAIL dir%0d_flags: got %b expected %b", i, f, dir_f[i]); end
      compared++;
      if (lat != dir_lat[i]) begin mismatched++;
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, dir_lat[i]); end
      compared++;
      if (rs) begin mismatched++;
        $display("FAIL dir%0d_in_ready_busy: got 1 expected 0", i); end
`ifdef SEQ_ALU_WIDE_RESULT_EN
      compared++;
      if (h !== dir_h[i]) begin mismatched++;
        $display("FAIL dir%0d_result_hi: got %h expected %h", i, h, dir_h[i]); end
`endif
      if (i == 0) begin
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin mismatched++;
          $display("FAIL dir0_out_valid_after_handshake: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, h, er, eh; logic [3:0] op, f, ef; int lat; bit rs, to;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(op, a, b, er, ef, eh);
      run_op(op, a, b, r, f, h, lat, rs, to);
      compared++;
      if (to) begin mismatched++; $display("FAIL rnd%0d_timeout: no response", i); continue; end
      compared++;
      if (r !== er) begin mismatched++;
        $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h expected %h", i, op, a, b, r, er); end
      compared++;
      if (f !== ef) begin mismatched++;
        $display("FAIL rnd%0d_flags op=%b a=%h b=%h: got %b expected %b", i, op, a, b, f, ef); end
      compared++;
      if (lat != exp_latency(op, b)) begin mismatched++;
        $display("FAIL rnd%0d_latency op=%b: got %0d expected %0d", i, op, lat, exp_latency(op, b)); end
`ifdef SEQ_ALU_WIDE_RESULT_EN
      compared++;
      if (h !== eh) begin mismatched++;
        $display("FAIL rnd%0d_result_hi op=%b a=%h b=%h: got %h expected %h", i, op, a, b, h, eh); end
`endif
    end
  endtask

  // Continuous single-cycle requests: one acceptance every 2 cycles.
  task automatic test_back_to_back();
    logic [W-1:0] er_q [$]; logic [3:0] ef_q [$];
    logic [W-1:0] er, eh, r_exp; logic [3:0] ef, f_exp, op;
    int accepted, last_acc, cyc; bit took;
    accepted = 0; last_acc = -1;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    op = 4'($urandom_range(0, 15)); if (op == 4'd2 || op == 4'd3) op = op + 4'd8;
    opcode = op; operand1 = W'($urandom); operand2 = W'($urandom);
    for (cyc = 0; cyc < 100 && (accepted < 20 || er_q.size() > 0); cyc++) begin
      took = 0;
      if (out_valid) begin
        compared++;
        if (er_q.size() == 0) begin mismatched++;
          $display("FAIL b2b_unexpected_out_valid: got 1 expected 0"); end
        else begin
          r_exp = er_q.pop_front(); f_exp = ef_q.pop_front();
          if (result !== r_exp || flags !== f_exp) begin mismatched++;
            $display("FAIL b2b_response: got %h/%b expected %h/%b", result, flags, r_exp, f_exp); end
          $display("b2b response result=%h flags=%b", result, flags);
        end
      end
      if (in_ready && in_valid) begin
        model(opcode, operand1, operand2, er, ef, eh);
        er_q.push_back(er); ef_q.push_back(ef);
        if (last_acc >= 0) begin
          compared++;
          if (cyc - last_acc != 2) begin mismatched++;
            $display("FAIL b2b_spacing: got %0d expected 2", cyc - last_acc); end
        end
        last_acc = cyc; accepted++; took = 1;
      end
      @(posedge clk); #1;
      if (took) begin
        op = 4'($urandom_range(0, 15)); if (op == 4'd2 || op == 4'd3) op = op + 4'd8;
        opcode = op; operand1 = W'($urandom); operand2 = W'($urandom);
        if (accepted >= 20) in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    compared++;
    if (accepted < 20 || er_q.size() != 0) begin mismatched++;
      $display("FAIL b2b_timeout: accepted %0d pending %0d expected 20/0", accepted, er_q.size()); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    opcode = 4'd0; operand1 = 16'h0002; operand2 = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    // Second request held pending while the first is stalled.
    opcode = 4'b1010; operand1 = 16'h00F0; operand2 = 16'h0F00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || result !== 16'h0005 || flags !== 4'b0000) begin mismatched++;
        $display("FAIL bp_hold%0d: got v=%b r=%h f=%b expected v=1 r=0005 f=0000", c, out_valid, result, flags); end
      compared++;
      if (in_ready !== 1'b0) begin mismatched++;
        $display("FAIL bp_in_ready%0d: got %b expected 0", c, in_ready); end
      $display("backpressure cycle %0d result=%h flags=%b", c, result, flags);
    end
    out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++;
      $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || result !== 16'h0FF0 || flags !== 4'b0000) begin mismatched++;
      $display("FAIL bp_second: got v=%b r=%h f=%b expected v=1 r=0FF0 f=0000", out_valid, result, flags); end
    $display("backpressure second request result=%h", result);
  endtask

  task automatic test_reset_mid_busy();
    logic [W-1:0] r, h; logic [3:0] f; int lat, n; bit rs, to;
    @(negedge clk);
    opcode = 4'd2; operand1 = W'($urandom) | 16'h0101; operand2 = W'($urandom) | 16'h0101;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin mismatched++;
      $display("FAIL rst_busy_before: got ready=%b valid=%b expected 0/0", in_ready, out_valid); end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || result !== '0 || flags !== 4'b0) begin mismatched++;
      $display("FAIL rst_busy_cleared: got v=%b r=%h f=%b expected 0/0000/0000", out_valid, result, flags); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++;
      $display("FAIL rst_busy_after: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    run_op(4'b1000, 16'h00FF, 16'h0F0F, r, f, h, lat, rs, to);
    compared++;
    if (to || r !== 16'h000F || f !== 4'b0000 || lat != 1) begin mismatched++;
      $display("FAIL rst_busy_and: got r=%h f=%b lat=%0d expected 000F/0000/1", r, f, lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
